// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : demux_pkg
//  Description : Shared constants, types and helpers for the registered
//                1-to-4 demultiplexer (demux14_reg) and its slot sub-module.
//                Contents:
//                  NUM_OUT     - number of output slots
//                  SEL_W       - width of the destination select
//                  DEF_WIDTH   - default data width
//                  DEF_CNT_W   - default transfer-counter width
//                  slot_idx_t  - slot index type
//                  sel_onehot  - select-to-one-hot decode helper
//  Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

  localparam int NUM_OUT   = 4;
  localparam int SEL_W     = 2;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;

  typedef logic [SEL_W-1:0] slot_idx_t;

  // One-hot decode of a slot index; bit N set selects slot N.
  function automatic logic [NUM_OUT-1:0] sel_onehot(input slot_idx_t idx);
    logic [NUM_OUT-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage : demux_pkg
`default_nettype wire

// File: rtl/demux_slot.sv
`default_nettype none
// ============================================================================
//  Module      : demux_slot
//  Description : Single-entry output slot: one data register plus full flag.
//                A push loads din and sets full; a pop clears full unless a
//                push lands in the same cycle, in which case the new word
//                replaces the departing one and full stays set.
//  Ports       : clk    - rising-edge clock
//                reset  - synchronous active-high reset
//                push   - load din this cycle (caller guarantees room)
//                pop    - consumer takes the word this cycle
//                din    - incoming data word
//                dout   - held data word (last loaded value)
//                full   - slot holds a valid word
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_slot #(
  parameter int WIDTH = demux_pkg::DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full
);

  logic [WIDTH-1:0] r_data;
  logic             r_full;

  // Data register only changes on push, so dout keeps the last loaded value
  // after the slot is drained.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= '0;
    end else if (push) begin
      r_data <= din;
    end
  end

  // Push has priority over pop: a simultaneous push/pop keeps the slot full
  // for one-word-per-cycle throughput. A pop on an empty slot is a no-op.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_full <= 1'b0;
    end else if (push) begin
      r_full <= 1'b1;
    end else if (pop && r_full) begin
      r_full <= 1'b0;
    end
  end

  assign dout = r_data;
  assign full = r_full;

endmodule : demux_slot
`default_nettype wire

// File: rtl/demux14_reg.sv
`default_nettype none
// ============================================================================
//  Module      : demux14_reg
//  Description : Registered 1-to-4 demultiplexer with valid/ready handshake.
//                A source word plus 2-bit select is steered into one of four
//                single-entry slots, each drained independently. Counts
//                accepted transfers in a wrapping counter.
//  Ports       : clk        - rising-edge clock
//                reset      - synchronous active-high reset
//                in         - source data word
//                s          - destination select (0..3 -> out0..out3)
//                in_valid   - source presents in/s this cycle
//                in_ready   - selected slot can accept (combinational)
//                out0..out3 - slot data, held while/after the slot is full
//                out_valid  - per-slot full flags
//                out_ready  - per-slot consumer take strobes
//                xfer_count - accepted-transfer count, wraps
//  Revision    : 1.0 - initial release
// ============================================================================
module demux14_reg #(
  parameter int WIDTH = demux_pkg::DEF_WIDTH,
  parameter int CNT_W = demux_pkg::DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       s,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [CNT_W-1:0] xfer_count
);

  import demux_pkg::*;

  slot_idx_t          w_sel;
  logic [NUM_OUT-1:0] w_sel_oh;
  logic [NUM_OUT-1:0] w_full;
  logic [NUM_OUT-1:0] w_push;
  logic               w_accept;
  logic [WIDTH-1:0]   w_dout [NUM_OUT];
  logic [CNT_W-1:0]   r_count;

  assign w_sel    = slot_idx_t'(s);
  assign w_sel_oh = sel_onehot(w_sel);

  // Ready looks only at the selected slot; a full slot can still accept when
  // its consumer drains it in the same cycle.
  assign in_ready = !w_full[w_sel] || out_ready[w_sel];
  assign w_accept = in_valid && in_ready;
  assign w_push   = w_accept ? w_sel_oh : '0;

  generate
    for (genvar n = 0; n < NUM_OUT; n++) begin : g_slot
      demux_slot #(
        .WIDTH (WIDTH)
      ) u_slot (
        .clk   (clk),
        .reset (reset),
        .push  (w_push[n]),
        .pop   (out_ready[n]),
        .din   (in),
        .dout  (w_dout[n]),
        .full  (w_full[n])
      );
    end
  endgenerate

  // Accepted-transfer counter; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_accept) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign out0       = w_dout[0];
  assign out1       = w_dout[1];
  assign out2       = w_dout[2];
  assign out3       = w_dout[3];
  assign out_valid  = w_full;
  assign xfer_count = r_count;

endmodule : demux14_reg
`default_nettype wire

// File: tb/tb_demux14_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux14_reg
//  Description : Directed self-checking bench for demux14_reg.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux14_reg;

  logic        clk;
  logic        reset;
  logic [7:0]  in;
  logic [1:0]  s;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out0, out1, out2, out3;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [15:0] xfer_count;

  int passed;
  int total;

  demux14_reg #(
    .WIDTH (8),
    .CNT_W (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in         (in),
    .s          (s),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0       (out0),
    .out1       (out1),
    .out2       (out2),
    .out3       (out3),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .xfer_count (xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    reset     = 1'b1;
    in        = 8'h00;
    s         = 2'd0;
    in_valid  = 1'b0;
    out_ready = 4'b0000;

    // ---- Reset state ----
    tick();
    reset = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 4'b0000);
    chk("rst_out0", out0, 8'h00);
    chk("rst_out1", out1, 8'h00);
    chk("rst_out2", out2, 8'h00);
    chk("rst_out3", out3, 8'h00);
    chk("rst_count", xfer_count, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      s = 2'(i);
      #1;
      chk("rst_in_ready", in_ready, 1'b1);
    end

    // ---- Single accept into slot 2 ----
    in = 8'hA5; s = 2'd2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("a5_out_valid", out_valid, 4'b0100);
    chk("a5_out2", out2, 8'hA5);
    chk("a5_count", xfer_count, 16'd1);
    // drain slot 2
    out_ready = 4'b0100;
    tick();
    out_ready = 4'b0000;
    chk("pop2_out_valid", out_valid, 4'b0000);
    chk("pop2_out2_held", out2, 8'hA5);

    // ---- Back-pressure on slot 1 ----
    in = 8'h11; s = 2'd1; in_valid = 1'b1;
    tick();
    chk("fill1_count", xfer_count, 16'd2);
    in = 8'h22;
    #1;
    chk("bp1_in_ready_low", in_ready, 1'b0);
    tick();
    chk("bp1_out1_held", out1, 8'h11);
    chk("bp1_out_valid", out_valid, 4'b0010);
    chk("bp1_count_same", xfer_count, 16'd2);
    out_ready = 4'b0010;
    #1;
    chk("bp1_in_ready_high", in_ready, 1'b1);
    tick();
    in_valid = 1'b0; out_ready = 4'b0000;
    chk("pp1_out1", out1, 8'h22);
    chk("pp1_out_valid", out_valid, 4'b0010);
    chk("pp1_count", xfer_count, 16'd3);
    out_ready = 4'b0010;
    tick();
    out_ready = 4'b0000;
    chk("pop1_out_valid", out_valid, 4'b0000);

    // ---- Blocked slot 3 does not affect slot 0 ----
    in = 8'h44; s = 2'd3; in_valid = 1'b1;
    tick();
    chk("fill3_out_valid", out_valid, 4'b1000);
    in = 8'h33;
    #1;
    chk("blk3_in_ready", in_ready, 1'b0);
    s = 2'd0;
    #1;
    chk("s0_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("s0_out_valid", out_valid, 4'b1001);
    chk("s0_out0", out0, 8'h33);
    chk("s0_count", xfer_count, 16'd5);

    // ---- Stream 8 words into slot 0 with consumer always ready ----
    out_ready = 4'b0001; s = 2'd0; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in = 8'(8'h50 + i);
      #1;
      chk("stream_in_ready", in_ready, 1'b1);
      tick();
      chk("stream_out0", out0, 32'(8'h50 + i));
      chk("stream_valid0", out_valid[0], 1'b1);
    end
    in_valid = 1'b0;
    tick();
    out_ready = 4'b0000;
    chk("stream_count", xfer_count, 16'd13);
    chk("stream_drained", out_valid, 4'b1000);

    // ---- in_valid low: no count change ----
    tick();
    chk("idle_count", xfer_count, 16'd13);

    // ---- Accept into slot 2 while popping slot 3 ----
    in = 8'h66; s = 2'd2; in_valid = 1'b1; out_ready = 4'b1000;
    tick();
    in_valid = 1'b0; out_ready = 4'b0000;
    chk("xpop_out_valid", out_valid, 4'b0100);
    chk("xpop_out2", out2, 8'h66);
    chk("xpop_out3_held", out3, 8'h44);

    // ---- Fill all slots, then reset with a simultaneous accept ----
    in_valid = 1'b1;
    in = 8'h70; s = 2'd0; tick();
    in = 8'h71; s = 2'd1; tick();
    in = 8'h73; s = 2'd3; tick();
    chk("all_full", out_valid, 4'b1111);
    chk("all_full_count", xfer_count, 16'd17);
    reset = 1'b1; in = 8'hFF; s = 2'd0; out_ready = 4'b1111;
    tick();
    reset = 1'b0; in_valid = 1'b0; out_ready = 4'b0000;
    chk("rst2_out_valid", out_valid, 4'b0000);
    chk("rst2_out0", out0, 8'h00);
    chk("rst2_out1", out1, 8'h00);
    chk("rst2_out2", out2, 8'h00);
    chk("rst2_out3", out3, 8'h00);
    chk("rst2_count", xfer_count, 16'h0000);

    // ---- Counter wrap ----
    s = 2'd1; in = 8'h5A; out_ready = 4'b0010; in_valid = 1'b1;
    repeat (65535) tick();
    chk("wrap_pre", xfer_count, 16'hFFFF);
    tick();
    in_valid = 1'b0; out_ready = 4'b0000;
    chk("wrap_post", xfer_count, 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_demux14_reg
`default_nettype wire
